// File: rtl/kestrel_bus_pkg.sv
// Shared types and widths for the Kestrel-2 split instruction/data bus.
package kestrel_bus_pkg;
    localparam int INS_ADR_W = 13;
    localparam int DAT_ADR_W = 15;
    localparam int WORD_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        DECIDE,
        DACCESS,
        ACK
    } bus_state_t;
endpackage

// File: rtl/shared_bus_responder_if.sv
// CPU-side instruction/data buses sharing one STB/ACK pair.
interface shared_bus_responder_if;
    import kestrel_bus_pkg::*;

    logic [INS_ADR_W-1:0] ins_adr_i;
    logic                 ins_cyc_i;
    logic [WORD_W-1:0]    ins_dat_o;
    logic [DAT_ADR_W-1:0] dat_adr_i;
    logic [WORD_W-1:0]    dat_dat_i;
    logic [WORD_W-1:0]    dat_dat_o;
    logic                 dat_we_i;
    logic                 dat_cyc_i;
    logic                 shr_stb_i;
    logic                 shr_ack_o;

    modport master (
        output ins_adr_i, ins_cyc_i, dat_adr_i, dat_dat_i, dat_we_i, dat_cyc_i, shr_stb_i,
        input  ins_dat_o, dat_dat_o, shr_ack_o
    );

    modport slave (
        input  ins_adr_i, ins_cyc_i, dat_adr_i, dat_dat_i, dat_we_i, dat_cyc_i, shr_stb_i,
        output ins_dat_o, dat_dat_o, shr_ack_o
    );
endinterface

// File: rtl/shared_bus_responder_wait_counter.sv
// Loadable 4-bit down-counter; last is high on the final cycle of a WAIT_STATES-long access.
module wait_counter #(
    parameter int WAIT_STATES = 2
) (
    input  logic sys_clk_i,
    input  logic sys_res_i,
    input  logic load,
    output logic last
);
    localparam logic [3:0] LOAD_VAL = 4'(WAIT_STATES);

    logic [3:0] cnt;

    always_ff @(posedge sys_clk_i or negedge sys_res_i) begin
        if (!sys_res_i)          cnt <= 4'd0;
        else if (load)           cnt <= LOAD_VAL;
        else if (cnt != 4'd0)    cnt <= cnt - 4'd1;
    end

    assign last = (cnt == 4'd1);
endmodule

// File: rtl/shared_bus_responder.sv
// Serves an instruction fetch plus an optional data load/store from one single-port
// word memory, then returns one ACK for the whole transaction.
module shared_bus_responder
    import kestrel_bus_pkg::*;
#(
    parameter int WAIT_STATES = 2    // legal 1..15
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_res_i,
    shared_bus_responder_if.slave bus,
    output logic [DAT_ADR_W-1:0] mem_adr_o,
    output logic [WORD_W-1:0]    mem_dat_o,
    input  logic [WORD_W-1:0]    mem_dat_i,
    output logic                 mem_ce_o,
    output logic                 mem_oe_o,
    output logic                 mem_we_o
);
    bus_state_t           state, state_n;
    logic                 cnt_load, cnt_last;
    logic                 abort, cap, ins_lat, dat_lat, we_n;
    logic [DAT_ADR_W-1:0] dadr_q;
    logic                 we_q;
    logic [WORD_W-1:0]    wd_q, ins_q, dat_q;
    logic                 ack_q, ce_q, oe_q, mwe_q;

    wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
        .sys_clk_i (sys_clk_i),
        .sys_res_i (sys_res_i),
        .load      (cnt_load),
        .last      (cnt_last)
    );

    always_comb begin
        state_n = state;
        cap     = 1'b0;
        ins_lat = 1'b0;
        dat_lat = 1'b0;
        abort   = (state inside {IFETCH, DECIDE, DACCESS}) && !bus.ins_cyc_i && !bus.dat_cyc_i;
        case (state)
            IDLE: begin
                if (bus.shr_stb_i) begin
                    if (bus.ins_cyc_i)      state_n = IFETCH;
                    else if (bus.dat_cyc_i) state_n = DECIDE;
                end
            end
            IFETCH: begin
                if (cnt_last) begin
                    state_n = DECIDE;
                    ins_lat = 1'b1;
                end
            end
            // dat_cyc_i is decoded by the master from the freshly latched ins_dat_o
            DECIDE: begin
                if (bus.dat_cyc_i) begin
                    state_n = DACCESS;
                    cap     = 1'b1;
                end else begin
                    state_n = ACK;
                end
            end
            DACCESS: begin
                if (cnt_last) begin
                    state_n = ACK;
                    dat_lat = !we_q;
                end
            end
            ACK: begin
                if (bus.shr_stb_i && bus.ins_cyc_i)      state_n = IFETCH;
                else if (bus.shr_stb_i && bus.dat_cyc_i) state_n = DECIDE;
                else                                     state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            cap     = 1'b0;
            ins_lat = 1'b0;
            dat_lat = 1'b0;
        end
        we_n     = cap ? bus.dat_we_i : we_q;
        cnt_load = (state_n == IFETCH  && state != IFETCH) ||
                   (state_n == DACCESS && state != DACCESS);
    end

    // Enables are registered from the next state so they line up with the state itself.
    always_ff @(posedge sys_clk_i or negedge sys_res_i) begin
        if (!sys_res_i) begin
            state  <= IDLE;
            ack_q  <= 1'b0;
            ce_q   <= 1'b0;
            oe_q   <= 1'b0;
            mwe_q  <= 1'b0;
            dadr_q <= '0;
            we_q   <= 1'b0;
            wd_q   <= '0;
            ins_q  <= '0;
            dat_q  <= '0;
        end else begin
            state <= state_n;
            ack_q <= (state == ACK);
            ce_q  <= (state_n == IFETCH) || (state_n == DACCESS);
            oe_q  <= (state_n == IFETCH) || (state_n == DACCESS && !we_n);
            mwe_q <= (state_n == DACCESS) && we_n;
            if (cap) begin
                dadr_q <= bus.dat_adr_i;
                we_q   <= bus.dat_we_i;
                wd_q   <= bus.dat_dat_i;
            end
            if (ins_lat) ins_q <= mem_dat_i;
            if (dat_lat) dat_q <= mem_dat_i;
        end
    end

    // The fetch address is taken live so the master can advance its pc on the ACK edge.
    assign mem_adr_o     = (state == IFETCH) ? DAT_ADR_W'(bus.ins_adr_i) : dadr_q;
    assign mem_dat_o     = wd_q;
    assign mem_ce_o      = ce_q;
    assign mem_oe_o      = oe_q;
    assign mem_we_o      = mwe_q;
    assign bus.ins_dat_o = ins_q;
    assign bus.dat_dat_o = dat_q;
    assign bus.shr_ack_o = ack_q;
endmodule

// File: tb/tb_shared_bus_responder.sv
// Random and directed transactions against a word-level memory model for shared_bus_responder.
module tb_shared_bus_responder;
    localparam int W2 = 2;
    localparam int W3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    shared_bus_responder_if bif2 ();
    shared_bus_responder_if bif3 ();

    logic [14:0] m2_adr, m3_adr;
    logic [15:0] m2_wd, m3_wd, m2_rd, m3_rd;
    logic        m2_ce, m2_oe, m2_we, m3_ce, m3_oe, m3_we;

    logic [15:0] mem2 [0:32767];
    logic [15:0] mem3 [0:32767];
    logic [15:0] ref_mem [0:32767];
    logic [15:0] last_ins;
    logic        dcyc_en2 = 1'b0;

    shared_bus_responder #(.WAIT_STATES(W2)) u2 (
        .sys_clk_i(clk), .sys_res_i(rst_n), .bus(bif2),
        .mem_adr_o(m2_adr), .mem_dat_o(m2_wd), .mem_dat_i(m2_rd),
        .mem_ce_o(m2_ce), .mem_oe_o(m2_oe), .mem_we_o(m2_we)
    );

    shared_bus_responder #(.WAIT_STATES(W3)) u3 (
        .sys_clk_i(clk), .sys_res_i(rst_n), .bus(bif3),
        .mem_adr_o(m3_adr), .mem_dat_o(m3_wd), .mem_dat_i(m3_rd),
        .mem_ce_o(m3_ce), .mem_oe_o(m3_oe), .mem_we_o(m3_we)
    );

    // Master decode: bit 11 requests a data access, bit 12 makes it a store.
    assign bif2.dat_cyc_i = dcyc_en2 & bif2.ins_dat_o[11];
    assign bif2.dat_we_i  = bif2.ins_dat_o[12];
    assign bif3.dat_cyc_i = 1'b0;
    assign bif3.dat_we_i  = 1'b0;

    assign m2_rd = mem2[m2_adr];
    assign m3_rd = mem3[m3_adr];
    always @(posedge clk) if (m2_ce && m2_we) mem2[m2_adr] <= m2_wd;
    always @(posedge clk) if (m3_ce && m3_we) mem3[m3_adr] <= m3_wd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic quiet_cycles(input string tag);
        int extra;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bif2.shr_ack_o || m2_we) extra++;
        end
        chk(tag, 32'(extra), 32'd0);
    endtask

    // kind: 0 = instruction only, 1 = load, 2 = store
    task automatic run_txn(input logic [12:0] a, input int kind, input logic [14:0] da,
                           input logic [15:0] wd);
        logic [15:0] iw, exp_ins, exp_dat;
        int cyc, we_cnt, we_bad, exp_lat;
        bit seen;
        iw = (kind == 0) ? 16'h6000 : (kind == 1) ? 16'h6C00 : 16'h7800;
        mem2[a] = iw;
        ref_mem[a] = iw;
        exp_ins = ref_mem[a];
        exp_dat = ref_mem[da];
        exp_lat = (kind == 0) ? 3 + W2 : 3 + 2 * W2;
        bif2.ins_adr_i = a;
        bif2.dat_adr_i = da;
        bif2.dat_dat_i = wd;
        bif2.shr_stb_i = 1'b1;
        bif2.ins_cyc_i = 1'b1;
        dcyc_en2 = 1'b1;
        cyc = 0; seen = 0; we_cnt = 0; we_bad = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (m2_we) begin
                we_cnt++;
                if (m2_adr !== da || m2_wd !== wd || !m2_ce) we_bad++;
            end
            if (bif2.shr_ack_o) seen = 1;
        end
        bif2.shr_stb_i = 1'b0;
        bif2.ins_cyc_i = 1'b0;
        dcyc_en2 = 1'b0;
        chk("ack_seen", 32'(seen), 32'd1);
        chk("ack_latency", 32'(cyc), 32'(exp_lat));
        chk("ins_dat", 32'(bif2.ins_dat_o), 32'(exp_ins));
        last_ins = exp_ins;
        if (kind == 1) chk("load_dat", 32'(bif2.dat_dat_o), 32'(exp_dat));
        chk("we_cycles", 32'(we_cnt), (kind == 2) ? 32'(W2) : 32'd0);
        if (kind == 2) begin
            chk("we_adr_dat", 32'(we_bad), 32'd0);
            ref_mem[da] = wd;
        end
        quiet_cycles("single_ack");
        if (kind == 2) chk("mem_store", 32'(mem2[da]), 32'(ref_mem[da]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] tmp;
        logic [14:0] da;
        logic [15:0] wd;
        int cyc, n, last_ack, acks;
        bit seen;

        for (int i = 0; i < 32768; i++) begin
            tmp = 16'($urandom);
            mem2[i] = tmp;
            ref_mem[i] = tmp;
            mem3[i] = 16'($urandom);
        end
        bif2.ins_adr_i = '0; bif2.dat_adr_i = '0; bif2.dat_dat_i = '0;
        bif2.shr_stb_i = 1'b0; bif2.ins_cyc_i = 1'b0;
        bif3.ins_adr_i = '0; bif3.dat_adr_i = '0; bif3.dat_dat_i = '0;
        bif3.shr_stb_i = 1'b0; bif3.ins_cyc_i = 1'b0;

        // Reset held with stimulus active
        @(negedge clk);
        bif2.shr_stb_i = 1'b1; bif2.ins_cyc_i = 1'b1; dcyc_en2 = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bif2.shr_ack_o || m2_ce || m2_oe || m2_we) acks++;
        end
        chk("rst_no_activity", 32'(acks), 32'd0);
        chk("rst_ins_dat", 32'(bif2.ins_dat_o), 32'd0);
        chk("rst_dat_dat", 32'(bif2.dat_dat_o), 32'd0);
        chk("rst_mem_dat", 32'(m2_wd), 32'd0);
        chk("rst_mem_adr", 32'(m2_adr), 32'd0);
        bif2.shr_stb_i = 1'b0; bif2.ins_cyc_i = 1'b0; dcyc_en2 = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: fetch, load, store
        run_txn(13'h0005, 0, 15'h0000, 16'h0000);
        ref_mem[15'h1234] = 16'hBEEF;
        mem2[15'h1234] = 16'hBEEF;
        run_txn(13'h0010, 1, 15'h1234, 16'h0000);
        run_txn(13'h0011, 2, 15'h0100, 16'hA5A5);

        // Abort mid-IFETCH: both cyc dropped
        mem2[13'h0020] = 16'h1234;
        bif2.ins_adr_i = 13'h0020;
        bif2.shr_stb_i = 1'b1; bif2.ins_cyc_i = 1'b1; dcyc_en2 = 1'b1;
        @(negedge clk);
        chk("abort_ce_active", 32'(m2_ce), 32'd1);
        bif2.shr_stb_i = 1'b0; bif2.ins_cyc_i = 1'b0; dcyc_en2 = 1'b0;
        @(negedge clk);
        chk("abort_ce_drop", 32'({m2_ce, m2_oe, m2_we}), 32'd0);
        quiet_cycles("abort_no_ack");
        chk("abort_ins_hold", 32'(bif2.ins_dat_o), 32'(last_ins));
        run_txn(13'h0021, 0, 15'h0000, 16'h0000);

        // Reset pulse during a store access
        mem2[13'h0030] = 16'h7800; ref_mem[13'h0030] = 16'h7800;
        bif2.ins_adr_i = 13'h0030; bif2.dat_adr_i = 15'h0200; bif2.dat_dat_i = 16'h5A5A;
        bif2.shr_stb_i = 1'b1; bif2.ins_cyc_i = 1'b1; dcyc_en2 = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (m2_we) seen = 1;
        end
        chk("rstw_we_seen", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_enables", 32'({m2_ce, m2_oe, m2_we}), 32'd0);
        chk("rstw_ins_dat", 32'(bif2.ins_dat_o), 32'd0);
        @(negedge clk);
        bif2.shr_stb_i = 1'b0; bif2.ins_cyc_i = 1'b0; dcyc_en2 = 1'b0;
        rst_n = 1'b1;
        quiet_cycles("rstw_no_ack");
        ref_mem[15'h0200] = mem2[15'h0200];
        run_txn(13'h0031, 1, 15'h0200, 16'h0000);

        // Random transactions
        for (int t = 0; t < 20; t++) begin
            da = 15'($urandom);
            wd = 16'($urandom);
            run_txn(13'($urandom_range(0, 8191)), int'($urandom_range(0, 2)), da, wd);
        end

        // Back-to-back instruction fetches with STB held, W=3
        for (int i = 0; i < 3; i++) mem3[i] = 16'($urandom) & 16'hF7FF;
        n = 0; cyc = 0; last_ack = 0;
        bif3.ins_adr_i = 13'd0;
        bif3.shr_stb_i = 1'b1; bif3.ins_cyc_i = 1'b1;
        while (n < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (m3_oe) chk("b2b_mem_adr", 32'(m3_adr), 32'(n));
            if (bif3.shr_ack_o) begin
                if (n == 0) chk("b2b_first_lat", 32'(cyc), 32'(3 + W3));
                else        chk("b2b_spacing", 32'(cyc - last_ack), 32'(2 + W3));
                chk("b2b_ins_dat", 32'(bif3.ins_dat_o), 32'(mem3[n]));
                last_ack = cyc;
                n++;
                bif3.ins_adr_i = 13'(n);
                if (n == 3) begin
                    bif3.shr_stb_i = 1'b0;
                    bif3.ins_cyc_i = 1'b0;
                end
            end
        end
        chk("b2b_ack_count", 32'(n), 32'd3);
        bif3.shr_stb_i = 1'b0; bif3.ins_cyc_i = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (bif3.shr_ack_o) acks++;
        end
        chk("b2b_no_extra", 32'(acks), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
